// File: rtl/multicycle_control_fsm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : multicycle_pkg                                                 |
// | Purpose : Shared types and encodings for the multi-cycle RV32I control   |
// |           FSM: state enum, opcode constants, ALU operand/op selects,     |
// |           decoded opcode class and the bundled control-output word.      |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package multicycle_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_RS1   = 2'd2;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;

  localparam logic [1:0] ALUC_ADD   = 2'd0;
  localparam logic [1:0] ALUC_FUNCT = 2'd1;
  localparam logic [1:0] ALUC_CMP   = 2'd2;

  // One-hot instruction class; exactly one field is set for any opcode.
  typedef struct packed {
    logic alu_r;
    logic alu_i;
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
    logic lui;
    logic auipc;
    logic ecall;
    logic illegal;
  } op_class_t;

  // All datapath controls; the all-zero value is the idle/quiescent word.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_ctrl;
    logic       is_halted;
    logic       illegal_inst;
  } ctrl_out_t;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_fsm_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : multicycle_control_fsm_if                                    |
// | Purpose   : Control/status bundle between the control FSM (master) and   |
// |             the shared datapath + memory (slave).                        |
// |             Status  : opcode, bcond, halt_cond, mem_ready                |
// |             Control : pc/mem/ir/rf enables, mux selects, alu_ctrl,       |
// |                       is_halted, illegal_inst                            |
// | Rev       : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
interface multicycle_control_fsm_if;
  logic [6:0] opcode;
  logic       bcond;
  logic       halt_cond;
  logic       mem_ready;

  logic       pc_write;
  logic       pc_write_cond;
  logic       pc_source;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_ctrl;
  logic       is_halted;
  logic       illegal_inst;

  modport master (
    input  opcode, bcond, halt_cond, mem_ready,
    output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_ctrl,
           is_halted, illegal_inst
  );

  modport slave (
    output opcode, bcond, halt_cond, mem_ready,
    input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_ctrl,
           is_halted, illegal_inst
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_fsm_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : opcode_class_decoder                                           |
// | Purpose : Combinational RV32I opcode -> one-hot instruction class.       |
// | Ports   : opcode   in  7   IR[6:0]                                       |
// |           op_class out 11  one-hot class, illegal for unknown opcodes    |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module opcode_class_decoder
  import multicycle_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  op_class
);

  always_comb begin
    op_class = '0;
    case (opcode)
      OP_R:      op_class.alu_r   = 1'b1;
      OP_IMM:    op_class.alu_i   = 1'b1;
      OP_LOAD:   op_class.load    = 1'b1;
      OP_STORE:  op_class.store   = 1'b1;
      OP_BRANCH: op_class.branch  = 1'b1;
      OP_JAL:    op_class.jal     = 1'b1;
      OP_JALR:   op_class.jalr    = 1'b1;
      OP_LUI:    op_class.lui     = 1'b1;
      OP_AUIPC:  op_class.auipc   = 1'b1;
      OP_ECALL:  op_class.ecall   = 1'b1;
      default:   op_class.illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : multicycle_control_fsm                                         |
// | Purpose : Sequences the shared multi-cycle RV32I datapath through        |
// |           IF/ID/EX/MEM/WB, waiting on mem_ready for memory accesses and  |
// |           halting on ecall with x17==10.                                 |
// | Ports   : clk    in  1  clock                                            |
// |           reset  in  1  asynchronous active-low reset (0 = in reset)     |
// |           ctrl   master modport of multicycle_control_fsm_if             |
// |           cycle_cnt / retired_cnt  out CNT_W  (MULTICYCLE_PERF_CNT_EN)   |
// | Config  : MULTICYCLE_PERF_CNT_EN adds the CNT_W-bit perf counters.       |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module multicycle_control_fsm
  import multicycle_pkg::*;
`ifdef MULTICYCLE_PERF_CNT_EN
#(
  parameter int CNT_W = 32
)
`endif
(
  input  logic                    clk,
  input  logic                    reset,
  multicycle_control_fsm_if.master ctrl
`ifdef MULTICYCLE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]        cycle_cnt,
  output logic [CNT_W-1:0]        retired_cnt
`endif
);

  state_t    r_state;
  state_t    w_next;
  op_class_t w_cls;
  ctrl_out_t w_out;
  ctrl_out_t w_out_gated;

  opcode_class_decoder u_dec (
    .opcode   (ctrl.opcode),
    .op_class (w_cls)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IF;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_out  = '0;
    case (r_state)
      S_IF: begin
        // PC+4 is computed every fetch cycle but only latched on the ready cycle.
        w_out.mem_read  = 1'b1;
        w_out.alu_src_a = SRCA_PC;
        w_out.alu_src_b = SRCB_FOUR;
        w_out.alu_ctrl  = ALUC_ADD;
        if (ctrl.mem_ready) begin
          w_out.ir_write = 1'b1;
          w_out.pc_write = 1'b1;
          w_next         = S_ID;
        end
      end
      S_ID: begin
        // Branch/JAL target precomputed into ALUOut.
        w_out.alu_src_a = SRCA_OLDPC;
        w_out.alu_src_b = SRCB_IMM;
        w_out.alu_ctrl  = ALUC_ADD;
        if (w_cls.ecall) begin
          w_next = ctrl.halt_cond ? S_HALT : S_IF;
        end else if (w_cls.illegal) begin
          w_out.illegal_inst = 1'b1;
          w_next             = S_IF;
        end else begin
          w_next = S_EX;
        end
      end
      S_EX: begin
        w_next = S_IF;
        if (w_cls.alu_r) begin
          w_out.alu_src_a = SRCA_RS1;
          w_out.alu_src_b = SRCB_RS2;
          w_out.alu_ctrl  = ALUC_FUNCT;
          w_next          = S_WB;
        end else if (w_cls.alu_i) begin
          w_out.alu_src_a = SRCA_RS1;
          w_out.alu_src_b = SRCB_IMM;
          w_out.alu_ctrl  = ALUC_FUNCT;
          w_next          = S_WB;
        end else if (w_cls.load || w_cls.store) begin
          w_out.alu_src_a = SRCA_RS1;
          w_out.alu_src_b = SRCB_IMM;
          w_out.alu_ctrl  = ALUC_ADD;
          w_next          = S_MEM;
        end else if (w_cls.branch) begin
          w_out.alu_src_a     = SRCA_RS1;
          w_out.alu_src_b     = SRCB_RS2;
          w_out.alu_ctrl      = ALUC_CMP;
          w_out.pc_write_cond = 1'b1;
          w_out.pc_source     = 1'b1;
        end else if (w_cls.jal) begin
          // PC already holds the return address; target sits in ALUOut.
          w_out.reg_write = 1'b1;
          w_out.pc_write  = 1'b1;
          w_out.pc_source = 1'b1;
        end else if (w_cls.jalr) begin
          w_out.reg_write = 1'b1;
          w_out.alu_src_a = SRCA_RS1;
          w_out.alu_src_b = SRCB_IMM;
          w_out.alu_ctrl  = ALUC_ADD;
          w_out.pc_write  = 1'b1;
        end else if (w_cls.lui) begin
          // rs1 field of LUI is x0 in the datapath, so RS1+imm yields imm.
          w_out.alu_src_a = SRCA_RS1;
          w_out.alu_src_b = SRCB_IMM;
          w_out.alu_ctrl  = ALUC_ADD;
          w_next          = S_WB;
        end else if (w_cls.auipc) begin
          w_out.alu_src_a = SRCA_OLDPC;
          w_out.alu_src_b = SRCB_IMM;
          w_out.alu_ctrl  = ALUC_ADD;
          w_next          = S_WB;
        end
      end
      S_MEM: begin
        w_out.i_or_d    = 1'b1;
        w_out.mem_read  = w_cls.load;
        w_out.mem_write = w_cls.store;
        if (ctrl.mem_ready) w_next = w_cls.load ? S_WB : S_IF;
      end
      S_WB: begin
        w_out.reg_write  = 1'b1;
        w_out.mem_to_reg = w_cls.load;
        w_next           = S_IF;
      end
      S_HALT: begin
        w_out.is_halted = 1'b1;
      end
      default: w_next = S_IF;
    endcase
  end

  // Controls are forced quiet for as long as reset is held, not just at the edge.
  assign w_out_gated = reset ? w_out : '0;

  assign ctrl.pc_write      = w_out_gated.pc_write;
  assign ctrl.pc_write_cond = w_out_gated.pc_write_cond;
  assign ctrl.pc_source     = w_out_gated.pc_source;
  assign ctrl.i_or_d        = w_out_gated.i_or_d;
  assign ctrl.mem_read      = w_out_gated.mem_read;
  assign ctrl.mem_write     = w_out_gated.mem_write;
  assign ctrl.ir_write      = w_out_gated.ir_write;
  assign ctrl.mem_to_reg    = w_out_gated.mem_to_reg;
  assign ctrl.reg_write     = w_out_gated.reg_write;
  assign ctrl.alu_src_a     = w_out_gated.alu_src_a;
  assign ctrl.alu_src_b     = w_out_gated.alu_src_b;
  assign ctrl.alu_ctrl      = w_out_gated.alu_ctrl;
  assign ctrl.is_halted     = w_out_gated.is_halted;
  assign ctrl.illegal_inst  = w_out_gated.illegal_inst;

`ifdef MULTICYCLE_PERF_CNT_EN
  logic             w_retire;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_retired_cnt;

  // Last cycle of an instruction: leaving a post-fetch state toward IF or HALT.
  assign w_retire = (r_state != S_IF) && (r_state != S_HALT) &&
                    ((w_next == S_IF) || (w_next == S_HALT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycle_cnt   <= '0;
      r_retired_cnt <= '0;
    end else if (r_state != S_HALT) begin
      r_cycle_cnt <= r_cycle_cnt + 1'b1;
      if (w_retire) r_retired_cnt <= r_retired_cnt + 1'b1;
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign retired_cnt = r_retired_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_multicycle_control_fsm                                      |
// | Purpose : Self-checking bench for multicycle_control_fsm. Directed       |
// |           reset/add/lw/illegal/halt scenarios plus randomized            |
// |           instruction streams checked against a per-instruction model    |
// |           of latency and control-pulse counts.                           |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_multicycle_control_fsm;

  localparam logic [6:0] T_R      = 7'b0110011;
  localparam logic [6:0] T_IMM    = 7'b0010011;
  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_JAL    = 7'b1101111;
  localparam logic [6:0] T_JALR   = 7'b1100111;
  localparam logic [6:0] T_LUI    = 7'b0110111;
  localparam logic [6:0] T_AUIPC  = 7'b0010111;
  localparam logic [6:0] T_ECALL  = 7'b1110011;
  localparam logic [6:0] T_BAD    = 7'h7F;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm_if bus ();

`ifdef MULTICYCLE_PERF_CNT_EN
  logic [31:0] cycle_cnt;
  logic [31:0] retired_cnt;
`endif

  multicycle_control_fsm dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus)
`ifdef MULTICYCLE_PERF_CNT_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .retired_cnt (retired_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All 17 control bits; is_halted is bit 1, illegal_inst bit 0.
  function automatic logic [16:0] outs();
    return {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.i_or_d,
            bus.mem_read, bus.mem_write, bus.ir_write, bus.mem_to_reg,
            bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_ctrl,
            bus.is_halted, bus.illegal_inst};
  endfunction

  // Zero-wait cycle count from fetch to the next fetch.
  function automatic int base_lat(input logic [6:0] op);
    case (op)
      T_R, T_IMM, T_LUI, T_AUIPC: return 4;
      T_LOAD:                     return 5;
      T_STORE:                    return 4;
      T_BRANCH, T_JAL, T_JALR:    return 3;
      default:                    return 2;
    endcase
  endfunction

  function automatic bit writes_rd(input logic [6:0] op);
    return op inside {T_R, T_IMM, T_LUI, T_AUIPC, T_LOAD, T_JAL, T_JALR};
  endfunction

  // Runs one instruction starting in the first IF cycle (posedge+1) and
  // compares per-instruction pulse counts with what the instruction class implies.
  task automatic run_instr(input logic [6:0] op, input int wif, input int wm, input bit halt);
    bit is_ld, is_st;
    int t_total, if_req, mem_req;
    int n_ir, n_pcw, n_rw, n_rd, n_wr, n_pcwc, n_ill, n_m2r, n_funct, n_cmp, n_both, n_waitpulse;
    string nm;
    is_ld = (op == T_LOAD);
    is_st = (op == T_STORE);
    t_total = base_lat(op) + wif + ((is_ld || is_st) ? wm : 0);
    {if_req, mem_req, n_ir, n_pcw, n_rw, n_rd, n_wr, n_pcwc} = '0;
    {n_ill, n_m2r, n_funct, n_cmp, n_both, n_waitpulse} = '0;
    bus.opcode    = op;
    bus.halt_cond = halt;
    for (int c = 0; c < t_total; c++) begin
      if (bus.mem_read || bus.mem_write) begin
        if (!bus.i_or_d) begin bus.mem_ready = (if_req == wif); if_req++; end
        else             begin bus.mem_ready = (mem_req == wm); mem_req++; end
      end else begin
        bus.mem_ready = 1'($urandom_range(0, 1));
      end
      bus.bcond = 1'($urandom_range(0, 1));
      #1;
      n_ir    += int'(bus.ir_write);
      n_pcw   += int'(bus.pc_write);
      n_rw    += int'(bus.reg_write);
      n_rd    += int'(bus.mem_read);
      n_wr    += int'(bus.mem_write);
      n_pcwc  += int'(bus.pc_write_cond);
      n_ill   += int'(bus.illegal_inst);
      n_m2r   += int'(bus.mem_to_reg);
      n_funct += int'(bus.alu_ctrl == 2'd1);
      n_cmp   += int'(bus.alu_ctrl == 2'd2);
      n_both  += int'(bus.mem_read && bus.mem_write);
      n_waitpulse += int'((bus.mem_read || bus.mem_write) && !bus.mem_ready &&
                          (bus.reg_write || bus.pc_write || bus.ir_write));
      @(posedge clk); #1;
    end
    nm = $sformatf("op%02h_wif%0d_wm%0d", op, wif, wm);
    check({nm, "_ir_write"},  n_ir,  1);
    check({nm, "_pc_write"},  n_pcw, 1 + int'(op == T_JAL || op == T_JALR));
    check({nm, "_reg_write"}, n_rw,  int'(writes_rd(op)));
    check({nm, "_mem_read"},  n_rd,  wif + 1 + (is_ld ? wm + 1 : 0));
    check({nm, "_mem_write"}, n_wr,  is_st ? wm + 1 : 0);
    check({nm, "_pcwc"},      n_pcwc, int'(op == T_BRANCH));
    check({nm, "_illegal"},   n_ill, int'(op == T_BAD));
    check({nm, "_mem_to_reg"}, n_m2r, int'(is_ld));
    check({nm, "_funct"},     n_funct, int'(op == T_R || op == T_IMM));
    check({nm, "_cmp"},       n_cmp, int'(op == T_BRANCH));
    check({nm, "_rd_and_wr"}, n_both, 0);
    check({nm, "_pulse_in_wait"}, n_waitpulse, 0);
    if (halt && op == T_ECALL)
      check({nm, "_halted"}, {bus.is_halted, bus.mem_read}, 2'b10);
    else
      check({nm, "_next_if"}, {bus.mem_read, bus.i_or_d, bus.is_halted}, 3'b100);
  endtask

  logic [6:0] ops [11];
  logic [5:0] add_sel [3];

  initial begin
    ops = '{T_R, T_IMM, T_LOAD, T_STORE, T_BRANCH, T_JAL, T_JALR,
            T_LUI, T_AUIPC, T_ECALL, T_BAD};
    // {alu_src_a, alu_src_b, alu_ctrl} for IF, ID, EX of an R-type.
    add_sel = '{6'b00_01_00, 6'b01_10_00, 6'b10_00_01};

    reset = 1'b0;
    bus.opcode = T_R; bus.bcond = 1'b0; bus.halt_cond = 1'b0; bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("reset_all_zero", outs(), 17'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("post_reset_if", {bus.mem_read, bus.i_or_d}, 2'b10);

    // add x3,x1,x2 with memory always ready: IF, ID, EX, WB.
    bus.opcode = T_R; bus.mem_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (c < 3) check($sformatf("add_sel_c%0d", c), {bus.alu_src_a, bus.alu_src_b, bus.alu_ctrl}, add_sel[c]);
      check($sformatf("add_rw_c%0d", c), bus.reg_write, (c == 3));
      @(posedge clk); #1;
    end
    check("add_next_if", {bus.mem_read, bus.i_or_d}, 2'b10);

    // lw with 3 fetch waits and 2 memory waits: 10 cycles.
    run_instr(T_LOAD, 3, 2, 1'b0);
    run_instr(T_BRANCH, 0, 0, 1'b0);
    run_instr(T_BRANCH, 1, 0, 1'b0);
    run_instr(T_ECALL, 0, 0, 1'b0);
    run_instr(T_BAD, 0, 0, 1'b0);

    for (int i = 0; i < 60; i++)
      run_instr(ops[$urandom_range(0, 10)], $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);

    // Reset asserted while a load waits in MEM.
    bus.opcode = T_LOAD; bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    check("mem_wait_state", {bus.mem_read, bus.i_or_d}, 2'b11);
    #2 reset = 1'b0;
    #1 check("reset_mid_mem_zero", outs(), 17'd0);
    @(posedge clk);
    @(negedge clk) reset = 1'b1;
    #1 check("reset_mid_mem_if", {bus.mem_read, bus.i_or_d}, 2'b10);
    @(posedge clk); #1;

    // ecall with x17==10 halts for good.
    run_instr(T_ECALL, 2, 0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.opcode    = ops[$urandom_range(0, 10)];
      bus.halt_cond = 1'($urandom_range(0, 1));
      #1 check($sformatf("halt_sticky_c%0d", c), outs(), 17'b10);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #2 check("halt_reset_zero", outs(), 17'd0);
    bus.mem_ready = 1'b0;
    @(negedge clk) reset = 1'b1;
    #1 check("halt_reset_if", {bus.mem_read, bus.i_or_d, bus.is_halted}, 3'b100);
    @(posedge clk); #1;
    run_instr(T_STORE, 1, 3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
